// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared types and constants for the hazard controller.
//   FWD_*   : ALU operand forwarding mux select codes
//   state_t : hazard FSM state encoding (RUN/STALL/FLUSH)
//   stage_t : shadow pipeline-stage entry {valid, rd, regwrite, memread}
package pipeline_pkg;

    localparam logic [1:0] FWD_RF  = 2'b00;  // register file
    localparam logic [1:0] FWD_MEM = 2'b01;  // EX/MEM result
    localparam logic [1:0] FWD_WB  = 2'b10;  // MEM/WB result

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } state_t;

    // Width of the rd field held in the shadow entries (RV32I: 32 registers).
    localparam int unsigned RD_W = 5;

    typedef struct packed {
        logic            valid;
        logic [RD_W-1:0] rd;
        logic            regwrite;
        logic            memread;
    } stage_t;

    localparam stage_t BUBBLE = '{valid: 1'b0, rd: '0, regwrite: 1'b0, memread: 1'b0};

    // Per-operand forwarding select. A load in EX never reaches here on an
    // advancing cycle because it forces a stall first.
    function automatic logic [1:0] fwd_select(input logic ex_hit, input logic ex_load,
                                              input logic mem_hit);
        if (ex_hit && !ex_load) begin
            return FWD_MEM;
        end else if (mem_hit) begin
            return FWD_WB;
        end
        return FWD_RF;
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: ID-stage hazard request and hazard-control response bundle.
//   master : pipeline side, drives the ID instruction fields and ex_branch_taken,
//            receives stall/flush/forwarding selects/debug state/stall counter.
//   slave  : hazard controller side (mirror of master).
interface hazard_ctrl_if #(
    parameter int unsigned REG_AW = 5,
    parameter int unsigned CNT_W  = 32
);
    logic              id_valid;
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic              id_use_rs1;
    logic              id_use_rs2;
    logic [REG_AW-1:0] id_rd;
    logic              id_regwrite;
    logic              id_memread;
    logic              ex_branch_taken;

    logic              stall;
    logic              flush;
    logic [1:0]        fwd_a_sel;
    logic [1:0]        fwd_b_sel;
    logic [1:0]        state;
    logic [CNT_W-1:0]  stall_count;

    modport master (
        output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd,
               id_regwrite, id_memread, ex_branch_taken,
        input  stall, flush, fwd_a_sel, fwd_b_sel, state, stall_count
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd,
               id_regwrite, id_memread, ex_branch_taken,
        output stall, flush, fwd_a_sel, fwd_b_sel, state, stall_count
    );
endinterface

// File: rtl/hazard_cmp.sv
// hazard_cmp: combinational check whether one shadow stage entry writes a
// given source register.
//   src    : source register index (REG_AW bits, REG_AW <= RD_W)
//   entry  : shadow stage entry
//   writes : entry is valid, writes a register, rd == src and src != x0
module hazard_cmp
    import pipeline_pkg::*;
#(
    parameter int unsigned REG_AW = 5
) (
    input  logic [REG_AW-1:0] src,
    input  stage_t            entry,
    output logic              writes
);

    logic [RD_W-1:0] src_w;
    logic            unused_memread;

    assign src_w  = RD_W'(src);
    assign writes = entry.valid & entry.regwrite & (entry.rd == src_w) & (src_w != '0);

    // Load-ness is judged by the caller, only for the EX entry.
    assign unused_memread = entry.memread;

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: hazard controller for the 5-stage RV32I pipeline.
// Tracks destination registers of the instructions in EX, MEM and WB and
// produces the RAW / load-use stall, the branch flush and the registered
// ALU operand forwarding selects.
//
// Ports:
//   clk   : core clock, rising edge
//   reset : synchronous, active-high
//   hz    : hazard_ctrl_if.slave (ID instruction fields, ex_branch_taken in;
//           stall, flush, fwd_a_sel, fwd_b_sel, state, stall_count out)
//
// Build option: define HAZARD_FORWARD_EN to enable forwarding; only load-use
// then stalls. Without it, selects are tied to FWD_RF and every RAW
// dependence on EX/MEM/WB stalls until the producer has left WB.
module hazard_ctrl
    import pipeline_pkg::*;
#(
    parameter int unsigned REG_AW = 5,
    parameter int unsigned CNT_W  = 32
) (
    input logic          clk,
    input logic          reset,
    hazard_ctrl_if.slave hz
);

    stage_t           ex_q, mem_q, wb_q;
    state_t           state_q;
    logic [CNT_W-1:0] stall_count_q;

    stage_t           stage [3];
    logic [2:0]       hit_rs1, hit_rs2;
    logic [2:0]       dep_a, dep_b;
    logic             stall_raw, stall, flush, advance;
    stage_t           id_entry;

    assign stage[0] = ex_q;
    assign stage[1] = mem_q;
    assign stage[2] = wb_q;

    for (genvar g = 0; g < 3; g++) begin : g_cmp
        hazard_cmp #(
            .REG_AW (REG_AW)
        ) u_cmp_rs1 (
            .src    (hz.id_rs1),
            .entry  (stage[g]),
            .writes (hit_rs1[g])
        );
        hazard_cmp #(
            .REG_AW (REG_AW)
        ) u_cmp_rs2 (
            .src    (hz.id_rs2),
            .entry  (stage[g]),
            .writes (hit_rs2[g])
        );
    end

    // Only sources the instruction actually reads can create a dependence.
    assign dep_a = hit_rs1 & {3{hz.id_use_rs1}};
    assign dep_b = hit_rs2 & {3{hz.id_use_rs2}};

`ifdef HAZARD_FORWARD_EN
    logic [1:0] fwd_a_q, fwd_b_q;
    logic       unused_wb_dep;

    assign stall_raw     = hz.id_valid & (dep_a[0] | dep_b[0]) & ex_q.memread;
    // WB producers are served by the register file write-through.
    assign unused_wb_dep = dep_a[2] ^ dep_b[2];
`else
    logic unused_ex_load;

    assign stall_raw      = hz.id_valid & ((|dep_a) | (|dep_b));
    assign unused_ex_load = ex_q.memread;
`endif

    // Flush wins over stall; both are forced low while reset is asserted.
    assign flush   = ~reset & hz.ex_branch_taken;
    assign stall   = ~reset & ~flush & stall_raw;
    assign advance = hz.id_valid & ~stall & ~flush;

    assign id_entry = '{valid: 1'b1, rd: RD_W'(hz.id_rd), regwrite: hz.id_regwrite,
                        memread: hz.id_memread};

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_q          <= BUBBLE;
            mem_q         <= BUBBLE;
            wb_q          <= BUBBLE;
            state_q       <= RUN;
            stall_count_q <= '0;
        end else begin
            wb_q  <= mem_q;
            mem_q <= ex_q;
            ex_q  <= advance ? id_entry : BUBBLE;
            if (flush) begin
                state_q <= FLUSH;
            end else if (stall) begin
                state_q <= STALL;
            end else begin
                state_q <= RUN;
            end
            if (stall) begin
                stall_count_q <= stall_count_q + 1'b1;
            end
        end
    end

`ifdef HAZARD_FORWARD_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            fwd_a_q <= FWD_RF;
            fwd_b_q <= FWD_RF;
        end else if (advance) begin
            fwd_a_q <= fwd_select(dep_a[0], ex_q.memread, dep_a[1]);
            fwd_b_q <= fwd_select(dep_b[0], ex_q.memread, dep_b[1]);
        end else begin
            fwd_a_q <= FWD_RF;
            fwd_b_q <= FWD_RF;
        end
    end

    assign hz.fwd_a_sel = fwd_a_q;
    assign hz.fwd_b_sel = fwd_b_q;
`else
    assign hz.fwd_a_sel = FWD_RF;
    assign hz.fwd_b_sel = FWD_RF;
`endif

    assign hz.stall       = stall;
    assign hz.flush       = flush;
    assign hz.state       = state_q;
    assign hz.stall_count = stall_count_q;

endmodule
